// File: rtl/router_pkg.sv
// Shared types and defaults for the output-port arbiter slice.
// Packet locking is compiled in only when the PKT_LOCK_EN macro is defined.
package router_pkg;

   localparam int unsigned DEF_NREQ    = 4;
   localparam int unsigned DEF_DASIZE  = 10;
   localparam int unsigned DEF_BUFSIZE = 4;
   localparam int unsigned TAIL_BIT    = DEF_DASIZE - 1;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   // Round-robin successor of idx among n requesters.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr.
module rr_picker
   import router_pkg::*;
#(
   parameter  int unsigned NREQ = DEF_NREQ,
   localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [IW-1:0]   rr_ptr,
   output logic            grant_valid,
   output logic [IW-1:0]   grant_idx
);

   // rr_ptr is always below NREQ, so one subtraction wraps the search slot.
   function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return IW'(s);
   endfunction

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = rr_ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!grant_valid && eligible[slot(rr_ptr, k)]) begin
            grant_valid = 1'b1;
            grant_idx   = slot(rr_ptr, k);
         end
      end
   end

endmodule

// File: rtl/output_port_arbiter.sv
// Credit-based round-robin arbiter feeding one output port from NREQ input FIFOs.
// Define PKT_LOCK_EN for wormhole packet locking; otherwise arbitration is per flit.
module output_port_arbiter
   import router_pkg::*;
#(
   parameter  int unsigned NREQ    = DEF_NREQ,
   parameter  int unsigned DASize  = DEF_DASIZE,
   parameter  int unsigned BUFSize = DEF_BUFSIZE,
   localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int unsigned CW      = $clog2(BUFSize + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_empty,
   input  logic [NREQ*DASize-1:0] req_data,
   output logic [NREQ-1:0]        read_en,
   output logic [DASize-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   credit_return,
   output logic [IW-1:0]          grant_id
);

`ifdef PKT_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   localparam int unsigned   TAIL       = DASize - 1;
   localparam logic [CW-1:0] CREDIT_MAX = CW'(BUFSize);

   arb_state_t          state, state_nxt;
   logic [IW-1:0]       rr_ptr, rr_ptr_nxt;
   logic [IW-1:0]       grant_nxt, issue_idx, rd_idx, grant_idx;
   logic [CW-1:0]       credits, credits_nxt;
   logic [NREQ-1:0]     eligible;
   logic                grant_valid, issue, tail_seen;
   logic [DASize-1:0]   flit [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_flit
      assign flit[g] = req_data[g*DASize +: DASize];
   end

   assign eligible = (credits != '0) ? ~req_empty : '0;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .eligible    (eligible),
      .rr_ptr      (rr_ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Flit arrives straight from the FIFO read port the cycle after its read strobe.
   assign out_data  = out_valid ? flit[rd_idx] : '0;
   assign tail_seen = out_valid & out_data[TAIL];

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      grant_nxt  = grant_id;
      issue      = 1'b0;
      issue_idx  = grant_id;
      read_en    = '0;
      if (!rst) begin
         if (LOCK_EN && state == LOCK) begin
            // Tail cycle releases the lock and leaves a single bubble.
            if (tail_seen)
               state_nxt = IDLE;
            else if (eligible[grant_id])
               issue = 1'b1;
         end else if (grant_valid) begin
            issue      = 1'b1;
            issue_idx  = grant_idx;
            grant_nxt  = grant_idx;
            rr_ptr_nxt = IW'(rr_next(32'(grant_idx), NREQ));
            if (LOCK_EN) state_nxt = LOCK;
         end
      end
      if (issue) read_en[issue_idx] = 1'b1;
   end

   // A read and a returning credit in the same cycle cancel out.
   always_comb begin
      credits_nxt = credits;
      if (issue && !credit_return)
         credits_nxt = credits - CW'(1);
      else if (!issue && credit_return && credits != CREDIT_MAX)
         credits_nxt = credits + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         credits   <= CREDIT_MAX;
         out_valid <= 1'b0;
         rd_idx    <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         grant_id  <= grant_nxt;
         credits   <= credits_nxt;
         out_valid <= issue;
         rd_idx    <= issue_idx;
      end
   end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed self-checking bench for output_port_arbiter with a simple FIFO model per requester.
// Lock-mode steps are compiled when PKT_LOCK_EN is defined.
module tb_output_port_arbiter;
   import router_pkg::*;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned DASize  = 10;
   localparam int unsigned BUFSize = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_empty;
   logic [NREQ*DASize-1:0] req_data;
   logic [NREQ-1:0]        read_en;
   logic [DASize-1:0]      out_data;
   logic                   out_valid;
   logic                   credit_return;
   logic [1:0]             grant_id;

   logic                   flush;
   bit   [DASize-1:0]      mem [NREQ][16];
   int unsigned            wr_ptr [NREQ];
   int unsigned            rd_ptr [NREQ];
   bit   [DASize-1:0]      rdata  [NREQ];

   int checks = 0;
   int errors = 0;

   output_port_arbiter #(.NREQ(NREQ), .DASize(DASize), .BUFSize(BUFSize)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_empty     (req_empty),
      .req_data      (req_data),
      .read_en       (read_en),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .credit_return (credit_return),
      .grant_id      (grant_id)
   );

   always #5 clk = ~clk;

   // Requester FIFO model: registered read data, valid the cycle after read_en.
   always @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (flush)
            rd_ptr[i] <= wr_ptr[i];
         else if (read_en[i] && rd_ptr[i] != wr_ptr[i]) begin
            rdata[i]  <= mem[i][rd_ptr[i] % 16];
            rd_ptr[i] <= rd_ptr[i] + 1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_empty[i]                  = (rd_ptr[i] == wr_ptr[i]);
         req_data[i*DASize +: DASize]  = rdata[i];
      end
   end

   task automatic push(input int r, input logic [DASize-1:0] v);
      mem[r][wr_ptr[r] % 16] = v;
      wr_ptr[r] = wr_ptr[r] + 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]        re038 [7];
      logic [DASize-1:0] d038  [6];
`ifdef PKT_LOCK_EN
      logic [3:0]        re034 [10];
      logic              ov034 [10];
      logic [DASize-1:0] d034  [10];
`endif
      re038 = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0000};
      d038  = '{10'h020, 10'h010, 10'h021, 10'h211, 10'h022, 10'h012};

      // Reset with a non-empty requester: no read may be issued.
      rst = 1'b1; flush = 1'b1; credit_return = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      push(0, 10'h005);
      #1 chk("rst_read_en", 32'(read_en), 32'h0);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_grant_id", 32'(grant_id), 32'h0);
      chk("rst_credits", 32'(dut.credits), 32'd4);
      chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));

      // First read and its one-cycle latency.
      rst = 1'b0;
      #1 chk("first_read_en", 32'(read_en), 32'b0001);
      @(negedge clk);
      chk("first_out_valid", 32'(out_valid), 32'h1);
      chk("first_out_data", 32'(out_data), 32'h005);
      chk("first_credits", 32'(dut.credits), 32'd3);
      chk("first_read_en_after", 32'(read_en), 32'h0);
      chk("first_rr_ptr", 32'(dut.rr_ptr), 32'h1);
      credit_return = 1'b1;
      @(negedge clk);
      chk("credit_back", 32'(dut.credits), 32'd4);

`ifndef PKT_LOCK_EN
      // Per-flit alternation between reqs 0 and 2; tail bit causes no bubble.
      push(0, 10'h010); push(0, 10'h211); push(0, 10'h012);
      push(2, 10'h020); push(2, 10'h021); push(2, 10'h022);
      #1;
      for (int k = 0; k < 7; k++) begin
         chk("alt_read_en", 32'(read_en), 32'(re038[k]));
         if (k > 0) begin
            chk("alt_out_valid", 32'(out_valid), 32'h1);
            chk("alt_out_data", 32'(out_data), 32'(d038[k-1]));
         end
         @(negedge clk);
      end
      chk("alt_end_valid", 32'(out_valid), 32'h0);
      chk("alt_end_data", 32'(out_data), 32'h0);
      chk("alt_credits_sat", 32'(dut.credits), 32'd4);
      credit_return = 1'b0;

      // Credit exhaustion: four reads, stall, then one read per returned credit.
      for (int v = 0; v < 6; v++) push(2, DASize'(10'h030 + v));
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("cred_read_en", 32'(read_en), 32'b0100);
         @(negedge clk);
      end
      chk("cred_stall_read_en", 32'(read_en), 32'h0);
      chk("cred_zero", 32'(dut.credits), 32'h0);
      chk("cred_last_data", 32'(out_data), 32'h033);
      @(negedge clk);
      chk("cred_stall2_read_en", 32'(read_en), 32'h0);
      chk("cred_stall2_valid", 32'(out_valid), 32'h0);
      credit_return = 1'b1;
      #1 chk("cred_pulse_read_en", 32'(read_en), 32'h0);
      @(negedge clk);
      credit_return = 1'b0;
      chk("cred_one", 32'(dut.credits), 32'h1);
      chk("cred_resume_read_en", 32'(read_en), 32'b0100);
      @(negedge clk);
      chk("cred_again_zero_read_en", 32'(read_en), 32'h0);
      chk("cred_again_zero", 32'(dut.credits), 32'h0);
      chk("cred_resume_data", 32'(out_data), 32'h034);
`endif

      // Reset one cycle after read_en[1]: in-flight flit dropped.
      rst = 1'b1; flush = 1'b1; credit_return = 1'b0;
      @(negedge clk);
      rst = 1'b0; flush = 1'b0;
      push(1, 10'h041);
      #1 chk("mid_read_en", 32'(read_en), 32'b0010);
      @(negedge clk);
      chk("mid_out_valid", 32'(out_valid), 32'h1);
      chk("mid_out_data", 32'(out_data), 32'h041);
      rst = 1'b1;
      #1 chk("mid_rst_read_en", 32'(read_en), 32'h0);
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data", 32'(out_data), 32'h0);
      chk("mid_rst_credits", 32'(dut.credits), 32'd4);
      chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
      chk("mid_rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
      chk("mid_rst_grant_id", 32'(grant_id), 32'h0);
      rst = 1'b0;

`ifdef PKT_LOCK_EN
      // Req 1 holds the port across an empty gap; req 3 waits for the tail.
      credit_return = 1'b1;
      push(1, 10'h001); push(1, 10'h002); push(3, 10'h210);
      #1 chk("lock_head_read_en", 32'(read_en), 32'b0010);
      @(negedge clk);
      chk("lock_head_data", 32'(out_data), 32'h001);
      chk("lock_body_read_en", 32'(read_en), 32'b0010);
      @(negedge clk);
      chk("lock_body_data", 32'(out_data), 32'h002);
      chk("lock_gap_read_en", 32'(read_en), 32'h0);
      @(negedge clk);
      chk("lock_gap_valid", 32'(out_valid), 32'h0);
      chk("lock_gap2_read_en", 32'(read_en), 32'h0);
      chk("lock_gap_state", 32'(dut.state), 32'(LOCK));
      push(1, 10'h203);
      #1 chk("lock_tail_read_en", 32'(read_en), 32'b0010);
      @(negedge clk);
      chk("lock_tail_data", 32'(out_data), 32'h203);
      chk("lock_bubble_read_en", 32'(read_en), 32'h0);
      @(negedge clk);
      chk("lock_release_state", 32'(dut.state), 32'(IDLE));
      chk("lock_req3_read_en", 32'(read_en), 32'b1000);
      @(negedge clk);
      chk("lock_req3_data", 32'(out_data), 32'h210);
      chk("lock_req3_bubble", 32'(read_en), 32'h0);
      @(negedge clk);
      chk("lock_idle_state", 32'(dut.state), 32'(IDLE));

      // Single-flit packets from every requester: 0,1,2,3,0 with a bubble each.
      re034 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
      ov034 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      d034  = '{10'h000, 10'h200, 10'h000, 10'h201, 10'h000, 10'h202, 10'h000, 10'h203, 10'h000, 10'h204};
      push(0, 10'h200); push(0, 10'h204);
      push(1, 10'h201); push(2, 10'h202); push(3, 10'h203);
      #1;
      for (int k = 0; k < 10; k++) begin
         chk("rr_read_en", 32'(read_en), 32'(re034[k]));
         chk("rr_out_valid", 32'(out_valid), 32'(ov034[k]));
         chk("rr_out_data", 32'(out_data), 32'(d034[k]));
         @(negedge clk);
      end
      credit_return = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
